// File: rtl/psram_arb_ctrl_pkg.sv
// Shared definitions for the PSRAM arbiter/controller slice.
//   state_e        controller FSM encoding
//   PORT_VID/CPU   requester indices into the 2-bit request/ack vectors
//   *_LVL          fixed pad levels for async-mode Cellular RAM and parked flash
//   WAIT_CNT_W     width of the strobe-hold down-counter
package psram_arb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam int PORT_VID = 0;
  localparam int PORT_CPU = 1;

  localparam logic ADV_LVL      = 1'b0;
  localparam logic CLK_LVL      = 1'b0;
  localparam logic CRE_LVL      = 1'b0;
  localparam logic FLASH_CS_LVL = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/psram_arb_ctrl_rr_arb_2.sv
// Two-requester round-robin arbiter.
//   clk, rst   clock and synchronous active-high reset
//   req        request vector, bit 0 = port 0
//   grant_en   a grant is being taken this cycle; updates last-grant
//   gnt        one-hot grant (combinational), zero when nothing requests
// On a tie the port that was not granted last wins. Reset leaves last-grant
// at port 1 so port 0 wins the first tie.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_d = last_q;
    if (grant_en && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/psram_arb_ctrl.sv
// Two-port arbiter and async-mode controller for the shared 16-bit Cellular
// RAM bus. Grants one fixed-length read or write at a time, drives registered
// active-low strobes, and parks the flash.
//   CLK_IN, RST_SYNC_IN          clock, synchronous active-high reset
//   REQ_IN/WE_IN/ADDRx/WDATAx/BEx per-port command, held until that port's ACK
//   ACK_OUT, RDATA_OUT           one-cycle completion pulse, read data
//   MEM_*/RAM_*/FLASH_CS_OUT     pad-side address, data, enables and strobes
//
// state   | meaning
// IDLE    | bus parked, arbitrate and latch the winner's command
// ACCESS  | strobes asserted for W cycles, read data captured on the last one
// RECOVER | strobes high, write data still driven for hold, ACK pulsed
module psram_arb_ctrl
  import psram_arb_ctrl_pkg::*;
#(
  parameter int RD_WAIT_CYCLES = 4,
  parameter int WR_WAIT_CYCLES = 4
) (
  input  logic        CLK_IN,
  input  logic        RST_SYNC_IN,
  input  logic [1:0]  REQ_IN,
  input  logic [1:0]  WE_IN,
  input  logic [22:0] ADDR0_IN,
  input  logic [22:0] ADDR1_IN,
  input  logic [15:0] WDATA0_IN,
  input  logic [15:0] WDATA1_IN,
  input  logic [1:0]  BE0_IN,
  input  logic [1:0]  BE1_IN,
  output logic [1:0]  ACK_OUT,
  output logic [15:0] RDATA_OUT,
  output logic [22:0] MEM_ADDR_OUT,
  output logic [15:0] MEM_DATA_OUT,
  output logic        MEM_DATA_OE_OUT,
  input  logic [15:0] MEM_DATA_IN,
  output logic        MEM_OE_OUT,
  output logic        MEM_WR_OUT,
  output logic        RAM_CS_OUT,
  output logic        RAM_LB_OUT,
  output logic        RAM_UB_OUT,
  output logic        RAM_ADV_OUT,
  output logic        RAM_CLK_OUT,
  output logic        RAM_CRE_OUT,
  output logic        FLASH_CS_OUT
);

  localparam logic [WAIT_CNT_W-1:0] RD_W = RD_WAIT_CYCLES[WAIT_CNT_W-1:0];
  localparam logic [WAIT_CNT_W-1:0] WR_W = WR_WAIT_CYCLES[WAIT_CNT_W-1:0];

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [22:0]           addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic [15:0]           rdata_q, rdata_d;
  logic [1:0]            ack_q, ack_d;
  logic                  cs_q, cs_d;
  logic                  oe_q, oe_d;
  logic                  wr_q, wr_d;
  logic                  lb_q, lb_d;
  logic                  ub_q, ub_d;
  logic                  data_oe_q, data_oe_d;

  logic                  grant_en;
  logic [1:0]            gnt;

  rr_arb_2 u_arb (
    .clk      (CLK_IN),
    .rst      (RST_SYNC_IN),
    .req      (REQ_IN),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  // Strobe flops are loaded with the level wanted in the *next* state, so the
  // pads see clean registered edges aligned to the state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    ack_d     = 2'b00;
    cs_d      = 1'b1;
    oe_d      = 1'b1;
    wr_d      = 1'b1;
    lb_d      = 1'b1;
    ub_d      = 1'b1;
    data_oe_d = 1'b0;
    grant_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ_IN != 2'b00) begin
          grant_en = 1'b1;
          state_d  = ST_ACCESS;
          if (gnt[PORT_CPU]) begin
            port_d  = 1'b1;
            we_d    = WE_IN[PORT_CPU];
            addr_d  = ADDR1_IN;
            wdata_d = WDATA1_IN;
            be_d    = BE1_IN;
          end else begin
            port_d  = 1'b0;
            we_d    = WE_IN[PORT_VID];
            addr_d  = ADDR0_IN;
            wdata_d = WDATA0_IN;
            be_d    = BE0_IN;
          end
          cnt_d     = we_d ? WR_W : RD_W;
          cs_d      = 1'b0;
          lb_d      = ~be_d[0];
          ub_d      = ~be_d[1];
          oe_d      = we_d;
          wr_d      = ~we_d;
          data_oe_d = we_d;
        end
      end

      ST_ACCESS: begin
        cnt_d     = cnt_q - 1'b1;
        data_oe_d = we_q;
        if (cnt_q == {{(WAIT_CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_RECOVER;
          if (!we_q) begin
            rdata_d = MEM_DATA_IN;
          end
          ack_d[port_q] = 1'b1;
        end else begin
          cs_d = 1'b0;
          lb_d = ~be_q[0];
          ub_d = ~be_q[1];
          oe_d = we_q;
          wr_d = ~we_q;
        end
      end

      ST_RECOVER: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_SYNC_IN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      ack_q     <= 2'b00;
      cs_q      <= 1'b1;
      oe_q      <= 1'b1;
      wr_q      <= 1'b1;
      lb_q      <= 1'b1;
      ub_q      <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      cs_q      <= cs_d;
      oe_q      <= oe_d;
      wr_q      <= wr_d;
      lb_q      <= lb_d;
      ub_q      <= ub_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign ACK_OUT         = ack_q;
  assign RDATA_OUT       = rdata_q;
  assign MEM_ADDR_OUT    = addr_q;
  assign MEM_DATA_OUT    = wdata_q;
  assign MEM_DATA_OE_OUT = data_oe_q;
  assign MEM_OE_OUT      = oe_q;
  assign MEM_WR_OUT      = wr_q;
  assign RAM_CS_OUT      = cs_q;
  assign RAM_LB_OUT      = lb_q;
  assign RAM_UB_OUT      = ub_q;
  assign RAM_ADV_OUT     = ADV_LVL;
  assign RAM_CLK_OUT     = CLK_LVL;
  assign RAM_CRE_OUT     = CRE_LVL;
  assign FLASH_CS_OUT    = FLASH_CS_LVL;

endmodule

// File: tb/tb_psram_arb_ctrl.sv
module tb_psram_arb_ctrl;

  localparam int W_RD = 4;
  localparam int W_WR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [22:0] addr0, addr1;
  logic [15:0] wd0, wd1;
  logic [1:0]  be0, be1;
  logic [1:0]  ack_out;
  logic [15:0] rdata_out, mem_data_out, mem_data_in;
  logic [22:0] mem_addr_out;
  logic        mem_data_oe, mem_oe, mem_wr, ram_cs, ram_lb, ram_ub;
  logic        ram_adv, ram_clk, ram_cre, flash_cs;

  logic [15:0] pad_ram [16];
  logic [15:0] mem_model [16];

  assign mem_data_in = pad_ram[mem_addr_out[3:0]];

  always #10 clk = ~clk;

  psram_arb_ctrl #(.RD_WAIT_CYCLES(W_RD), .WR_WAIT_CYCLES(W_WR)) dut (
    .CLK_IN(clk), .RST_SYNC_IN(rst), .REQ_IN(req), .WE_IN(we),
    .ADDR0_IN(addr0), .ADDR1_IN(addr1), .WDATA0_IN(wd0), .WDATA1_IN(wd1),
    .BE0_IN(be0), .BE1_IN(be1), .ACK_OUT(ack_out), .RDATA_OUT(rdata_out),
    .MEM_ADDR_OUT(mem_addr_out), .MEM_DATA_OUT(mem_data_out),
    .MEM_DATA_OE_OUT(mem_data_oe), .MEM_DATA_IN(mem_data_in),
    .MEM_OE_OUT(mem_oe), .MEM_WR_OUT(mem_wr), .RAM_CS_OUT(ram_cs),
    .RAM_LB_OUT(ram_lb), .RAM_UB_OUT(ram_ub), .RAM_ADV_OUT(ram_adv),
    .RAM_CLK_OUT(ram_clk), .RAM_CRE_OUT(ram_cre), .FLASH_CS_OUT(flash_cs)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;   // 0: drop req on ack, 1: keep req, 2: random traffic, 3: drain

  // Transaction-level model: one access in flight, identified by its start cycle.
  bit          m_busy;
  int          m_t0, m_w, m_port, m_last;
  bit          m_we;
  logic [22:0] m_addr;
  logic [15:0] m_wd;
  logic [1:0]  m_be;
  logic [15:0] e_rdata, e_wdata;
  logic [22:0] e_addr;
  bit          prev_oe = 1'b1;
  bit          prev_doe = 1'b0;
  int          ack_port_log[$];
  int          ack_cyc_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1;
    e_rdata = '0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_arbitrate();
    int p;
    if (!m_busy && req != 2'b00) begin
      if (req == 2'b01)      p = 0;
      else if (req == 2'b10) p = 1;
      else                   p = 1 - m_last;
      m_last = p; m_busy = 1'b1; m_t0 = cyc; m_port = p;
      m_we   = we[p];
      m_addr = (p == 1) ? addr1 : addr0;
      m_wd   = (p == 1) ? wd1 : wd0;
      m_be   = (p == 1) ? be1 : be0;
      m_w    = m_we ? W_WR : W_RD;
      e_addr = m_addr; e_wdata = m_wd;
    end
  endtask

  task automatic new_cmd(input int p);
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    a = 23'($urandom); d = 16'($urandom); b = 2'($urandom);
    we[p] = 1'($urandom);
    if (p == 1) begin addr1 = a; wd1 = d; be1 = b; end
    else        begin addr0 = a; wd0 = d; be0 = b; end
    req[p] = 1'b1;
  endtask

  task automatic cycle();
    bit rst_now;
    int k;
    logic e_cs, e_oe, e_wr, e_lb, e_ub, e_doe;
    logic [1:0] e_ack;
    rst_now = rst;
    if (!rst_now) model_arbitrate();
    // bench RAM part: byte lanes written while the write strobes are low
    if (ram_cs === 1'b0 && mem_wr === 1'b0 && mem_data_oe === 1'b1) begin
      if (!ram_lb) pad_ram[mem_addr_out[3:0]][7:0]  = mem_data_out[7:0];
      if (!ram_ub) pad_ram[mem_addr_out[3:0]][15:8] = mem_data_out[15:8];
    end
    @(posedge clk); #1;
    cyc++;
    if (rst_now) model_reset();
    e_cs = 1; e_oe = 1; e_wr = 1; e_lb = 1; e_ub = 1; e_doe = 0; e_ack = 2'b00;
    if (m_busy && cyc >= m_t0 + m_w + 2) m_busy = 1'b0;
    if (m_busy) begin
      k = cyc - m_t0;
      if (k >= 1 && k <= m_w) begin
        e_cs = 0; e_lb = ~m_be[0]; e_ub = ~m_be[1];
        e_oe = m_we; e_wr = ~m_we; e_doe = m_we;
      end else if (k == m_w + 1) begin
        e_doe = m_we;
        e_ack[m_port] = 1'b1;
        if (m_we) begin
          if (m_be[0]) mem_model[m_addr[3:0]][7:0]  = m_wd[7:0];
          if (m_be[1]) mem_model[m_addr[3:0]][15:8] = m_wd[15:8];
        end else begin
          e_rdata = mem_model[m_addr[3:0]];
        end
      end
    end
    chk("strobes{cs,oe,wr,lb,ub,doe}", {ram_cs, mem_oe, mem_wr, ram_lb, ram_ub, mem_data_oe},
        {e_cs, e_oe, e_wr, e_lb, e_ub, e_doe});
    chk("ack", ack_out, e_ack);
    chk("rdata", rdata_out, e_rdata);
    chk("mem_addr", mem_addr_out, e_addr);
    chk("mem_data", mem_data_out, e_wdata);
    chk("consts{flash,adv,clk,cre}", {flash_cs, ram_adv, ram_clk, ram_cre}, 4'b1000);
    chk("oe_and_data_oe", {mem_oe == 1'b0 && mem_data_oe == 1'b1}, 0);
    if (prev_oe && mem_oe == 1'b0) chk("turnaround_doe_before_oe", prev_doe, 0);
    prev_oe = mem_oe; prev_doe = mem_data_oe;
    for (int p = 0; p < 2; p++) begin
      if (e_ack[p]) begin
        ack_port_log.push_back(p);
        ack_cyc_log.push_back(cyc);
        if (mode == 0 || mode == 3) req[p] = 1'b0;
        else if (mode == 2) begin
          if ($urandom_range(1, 0) == 1) new_cmd(p);
          else req[p] = 1'b0;
        end
      end else if (mode == 2 && !req[p] && $urandom_range(3, 0) == 0) begin
        new_cmd(p);
      end
    end
  endtask

  task automatic wait_ack(input int p, output int at);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      cycle();
      if (ack_out[p]) at = cyc;
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout: port %0d got no ACK within 40 cycles", p);
    end
  endtask

  initial begin
    int t0, at, cnt_a, cnt_b;
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; be0 = 2'b11; be1 = 2'b11;
    for (int i = 0; i < 16; i++) begin
      pad_ram[i]   = 16'(i * 16'h1111) ^ 16'h0F0F;
      mem_model[i] = pad_ram[i];
    end
    model_reset();

    // reset state
    cycle(); cycle();
    chk("rst_strobes", {ram_cs, mem_oe, mem_wr, ram_lb, ram_ub}, 5'b11111);
    chk("rst_data_oe", mem_data_oe, 0);
    chk("rst_ack", ack_out, 2'b00);
    chk("rst_rdata", rdata_out, 16'h0000);
    chk("rst_flash_adv", {flash_cs, ram_adv}, 2'b10);

    // both ports request continuously from reset: 0,1,0,1 spaced 6 cycles
    mode = 1; req = 2'b11; we = 2'b00;
    addr0 = 23'h000004; addr1 = 23'h000005;
    cycle();
    rst = 1'b0;
    ack_port_log.delete(); ack_cyc_log.delete();
    for (int i = 0; i < 60 && ack_port_log.size() < 4; i++) cycle();
    chk("rr_ack_count", ack_port_log.size(), 4);
    if (ack_port_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", ack_port_log[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", ack_cyc_log[i] - ack_cyc_log[i-1], 6);
    end
    mode = 0; req = 2'b00;
    for (int i = 0; i < 8; i++) cycle();

    // port 1 read of 0x123456 returning 0xBEEF
    pad_ram[6] = 16'hBEEF; mem_model[6] = 16'hBEEF;
    addr1 = 23'h123456; we[1] = 1'b0; be1 = 2'b11; req = 2'b10;
    t0 = cyc; cnt_a = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i <= 4 && ram_cs == 1'b0 && mem_oe == 1'b0) cnt_a++;
      if (i == 5) begin
        chk("rd_ack_t0+5", ack_out, 2'b10);
        chk("rd_data", rdata_out, 16'hBEEF);
      end
    end
    chk("rd_cs_oe_low_cycles", cnt_a, 4);
    chk("rd_done_cycle", cyc - t0, 6);

    // port 0 write, low byte only
    pad_ram[0] = 16'h1234; mem_model[0] = 16'h1234;
    addr0 = 23'h000010; wd0 = 16'hA55A; be0 = 2'b01; we[0] = 1'b1; req = 2'b01;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i <= 4 && mem_wr == 1'b0 && ram_lb == 1'b0 && ram_ub == 1'b1) cnt_a++;
      if (i <= 5 && mem_data_oe == 1'b1 && mem_data_out == 16'hA55A) cnt_b++;
      if (i == 5) chk("wr_ack_t0+5", ack_out, 2'b01);
    end
    chk("wr_strobe_cycles", cnt_a, 4);
    chk("wr_data_driven_cycles", cnt_b, 5);
    chk("wr_mem_low_byte", pad_ram[0], 16'h125A);

    // reset in the middle of a write, then the held request completes afresh
    addr0 = 23'h000022; wd0 = 16'h0F0F; be0 = 2'b11; we[0] = 1'b1; req = 2'b01;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("abort_wr_cs", {mem_wr, ram_cs}, 2'b11);
    chk("abort_data_oe", mem_data_oe, 0);
    chk("abort_ack", ack_out, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = pad_ram[i];
    t0 = cyc;
    wait_ack(0, at);
    chk("abort_fresh_latency", at - t0, 5);
    for (int i = 0; i < 3; i++) cycle();

    // write immediately followed by a read of the same word
    addr0 = 23'h000033; wd0 = 16'h6C3E; be0 = 2'b11; we[0] = 1'b1; req = 2'b01;
    cycle();
    addr1 = 23'h7F0033; be1 = 2'b11; we[1] = 1'b0; req[1] = 1'b1;
    wait_ack(1, at);
    chk("rd_after_wr_data", rdata_out, 16'h6C3E);
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic against the model, then drain
    mode = 2;
    for (int i = 0; i < 3000; i++) cycle();
    mode = 3;
    for (int i = 0; i < 40; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_arb_ctrl.md
Name: psram_arb_ctrl

Overview:
Two-port arbiter and asynchronous-mode controller for the board's shared 16-bit Cellular RAM bus (MEM_ADDR[23:1], MEM_DATA[15:0], OE/WR, RAM_* controls). It grants the memory to one of two requesters (port 0: video/EPP, port 1: CPU), using round-robin arbitration. It sequences fixed-length read and write accesses with registered strobes, and keeps the flash deselected. It sits inside the bus top, between the requester fabric and the pad-level tristate logic.

Parameters:
RD_WAIT_CYCLES, 4, cycles the read strobes (CS/OE) are held; legal range 1..15 (4 x 20 ns = 80 ns covers the 70 ns part at 50 MHz)
WR_WAIT_CYCLES, 4, cycles the write strobes (CS/WE) are held; legal range 1..15

Ports:
CLK_IN  in  1  50 MHz master clock
RST_SYNC_IN  in  1  reset; synchronous, active-high
REQ_IN  in  2  per-port request; held with stable command until that port's ACK
WE_IN  in  2  per-port: 1 = write, 0 = read
ADDR0_IN / ADDR1_IN  in  23  word address [23:1]
WDATA0_IN / WDATA1_IN  in  16  write data
BE0_IN / BE1_IN  in  2  byte enables; [0] = low byte, [1] = high byte
ACK_OUT  in/out: out  2  per-port one-cycle completion pulse
RDATA_OUT  out  16  read data; valid in the ACK cycle and held until the next read completes
MEM_ADDR_OUT  out  23  address to pads
MEM_DATA_OUT  out  16  write data to pads
MEM_DATA_OE_OUT  out  1  high = FPGA drives MEM_DATA
MEM_DATA_IN  in  16  data from pads
MEM_OE_OUT, MEM_WR_OUT, RAM_CS_OUT, RAM_LB_OUT, RAM_UB_OUT  out  1 each  active-low strobes
RAM_ADV_OUT, RAM_CLK_OUT, RAM_CRE_OUT  out  1 each  constants 0, 0, 0 (async mode)
FLASH_CS_OUT  out  1  constant 1 (flash deselected)

Behaviour:
- Every output is registered, except the constants.
- Reset values:
  - MEM_OE_OUT = MEM_WR_OUT = RAM_CS_OUT = RAM_LB_OUT = RAM_UB_OUT = 1
  - MEM_DATA_OE_OUT = 0, ACK_OUT = 0, RDATA_OUT = 0, MEM_ADDR_OUT = 0, MEM_DATA_OUT = 0
  - FSM = IDLE; last-grant register = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE (call this cycle t0):
  - If any REQ_IN is high, pick a winner and latch its ADDR, WE, WDATA and BE. Go to ACCESS. Load the wait counter with RD_WAIT_CYCLES or WR_WAIT_CYCLES.
  - Otherwise stay in IDLE.
- ACCESS (cycles t0+1 .. t0+W, W = selected wait count):
  - RAM_CS_OUT = 0; LB = ~BE[0]; UB = ~BE[1]; address stable.
  - Read: MEM_OE_OUT = 0.
  - Write: MEM_WR_OUT = 0 and MEM_DATA_OE_OUT = 1.
  - The counter decrements each cycle. On the last ACCESS cycle a read captures MEM_DATA_IN into RDATA_OUT. Then go to RECOVER.
- RECOVER (cycle t0+W+1):
  - CS, OE, WR, LB and UB all deasserted (high). The address is held.
  - A write keeps MEM_DATA_OE_OUT = 1 and the data stable for this cycle (hold time). MEM_DATA_OE_OUT drops at the end of the cycle.
  - ACK_OUT[winner] = 1 for exactly this cycle. Go to IDLE.
- Latency and throughput: ACK arrives W+1 cycles after the REQ sampling cycle. Back-to-back throughput is one access per W+2 cycles.
- Arbitration:
  - A single requester always wins.
  - If both request, the port not granted last wins; last-grant updates on every grant.
  - Requests arriving during ACCESS/RECOVER wait for IDLE.
  - No preemption.
- Handshake: the requester deasserts REQ, or presents its next command, on the clock edge that ends its ACK cycle. A REQ still high in IDLE is treated as a new request.
- A BE = 00 access is still sequenced with both lanes disabled, and ACK is still returned.
- Reset mid-operation: on the next edge all strobes go inactive, MEM_DATA_OE_OUT = 0, FSM = IDLE. No ACK is issued for the aborted access.
- MEM_DATA_OE_OUT is never high while MEM_OE_OUT = 0. An IDLE cycle always separates accesses (bus turnaround).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ACCESS, RECOVER)
  - port index constants (PORT_VID = 0, PORT_CPU = 1)
  - async-mode constant levels for ADV, CLK, CRE and FLASH_CS
  - wait-counter width (4)
- Sub-module: rr_arb_2, a two-requester round-robin arbiter with its last-grant register, a grant-enable input and a one-hot grant output.

Test Plan:
- Reset with REQ = 00 -> all strobes high, MEM_DATA_OE_OUT = 0, ACK = 00, RDATA_OUT = 0x0000, FLASH_CS_OUT = 1, RAM_ADV_OUT = 0.
- Port 1 read, ADDR = 0x123456, BE = 11, memory model returns 0xBEEF, W = 4:
  - CS/OE low for cycles t0+1..t0+4
  - ACK_OUT = 10 at t0+5 with RDATA_OUT = 0xBEEF
  - IDLE at t0+6
- Port 0 write, ADDR = 0x000010, WDATA = 0xA55A, BE = 01:
  - WR low and LB low with UB high for 4 cycles
  - data driven through t0+5
  - ACK_OUT = 01 at t0+5
  - model low byte = 0x5A, high byte unchanged
- Both ports request continuously from reset -> grants alternate 0, 1, 0, 1; each ACK is spaced 6 cycles apart; no port is starved.
- Assert RST_SYNC_IN at t0+2 of a write -> next edge WR/CS high and DATA_OE = 0; ACK never issued; a fresh request after reset completes normally.
- Read immediately following a write (back-to-back requests) -> at least one cycle with MEM_DATA_OE_OUT = 0 before MEM_OE_OUT falls; the assertion that OE and DATA_OE are never both active holds throughout.
